// File: rtl/wbck_arbiter.sv
// ----------------------------------------------------------------------------
// wbck_arbiter
//
// Purpose:
//   Writeback-side producer for the general register file. It merges two
//   sources of register-write results into one registered write per cycle:
//     - the single-cycle ALU path (valid/ready handshake, no buffering);
//     - the long-latency LSU path, buffered in a small in-order FIFO.
//   The ALU normally has priority. The LSU FIFO head is forced through when
//   the FIFO is full, or when it has lost arbitration STARVE_MAX times in a
//   row. Writes that target x0 are consumed but never raise the write enable.
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   i_alu_valid/idx/dat   ALU result request
//   o_alu_ready           ALU request accepted when valid & ready
//   i_lsu_valid/idx/dat   LSU result request
//   o_lsu_ready           LSU FIFO can accept (not full)
//   wbck_dest_wen/idx/dat registered regfile write port
//   o_lsu_pending         LSU FIFO non-empty
//   o_alu_stall_cnt       (WBCK_PERF_EN only) wrapping count of cycles in
//                         which the ALU was valid but not ready
//
// Configuration macro:
//   WBCK_PERF_EN  adds the o_alu_stall_cnt port and its counter.
// ----------------------------------------------------------------------------
module wbck_arbiter #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int LSU_DEPTH  = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alu_valid,
  output logic               o_alu_ready,
  input  logic [RFIDX_W-1:0] i_alu_idx,
  input  logic [XLEN-1:0]    i_alu_dat,
  input  logic               i_lsu_valid,
  output logic               o_lsu_ready,
  input  logic [RFIDX_W-1:0] i_lsu_idx,
  input  logic [XLEN-1:0]    i_lsu_dat,
  output logic               wbck_dest_wen,
  output logic [RFIDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]    wbck_dest_dat,
  output logic               o_lsu_pending
`ifdef WBCK_PERF_EN
  ,
  output logic [31:0]        o_alu_stall_cnt
`endif
);

  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int CNT_W = $clog2(LSU_DEPTH + 1);
  localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(LSU_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE_C  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ST_W-1:0]  ST_MAX_C   = ST_W'(STARVE_MAX);
  localparam logic [ST_W-1:0]  ST_ZERO_C  = {ST_W{1'b0}};
  localparam logic [ST_W-1:0]  ST_ONE_C   = {{(ST_W-1){1'b0}}, 1'b1};
  localparam logic [RFIDX_W-1:0] IDX_ZERO_C = {RFIDX_W{1'b0}};

  // FIFO storage and control state
  logic [RFIDX_W-1:0] mem_idx_q [LSU_DEPTH];
  logic [XLEN-1:0]    mem_dat_q [LSU_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ST_W-1:0]    starve_q, starve_d;

  // Output stage registers
  logic               wen_q, wen_d;
  logic [RFIDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]    dat_q, dat_d;

  // Arbitration signals
  logic               nonempty_s;
  logic               full_s;
  logic               force_lsu_s;
  logic               lsu_win_s;
  logic               alu_win_s;
  logic               push_s;
  logic               pop_s;
  logic [RFIDX_W-1:0] head_idx_s;
  logic [XLEN-1:0]    head_dat_s;

  // Arbitration decision; depends only on registered FIFO state and ALU valid.
  always_comb begin
    nonempty_s  = (count_q != CNT_ZERO_C);
    full_s      = (count_q == FULL_C);
    force_lsu_s = full_s | (starve_q == ST_MAX_C);
    // A full FIFO refuses the push even if it pops this cycle.
    o_lsu_ready = !full_s;
    o_alu_ready = !(force_lsu_s & nonempty_s);
    lsu_win_s   = nonempty_s & (force_lsu_s | !i_alu_valid);
    alu_win_s   = i_alu_valid & o_alu_ready;
    push_s      = i_lsu_valid & !full_s;
    pop_s       = lsu_win_s;
    head_idx_s  = mem_idx_q[rd_ptr_q];
    head_dat_s  = mem_dat_q[rd_ptr_q];
  end

  // FIFO pointer, occupancy and starvation next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase

    // The counter measures consecutive losses of a waiting head only.
    if (pop_s || !nonempty_s) begin
      starve_d = ST_ZERO_C;
    end else if (alu_win_s && (starve_q != ST_MAX_C)) begin
      starve_d = starve_q + ST_ONE_C;
    end else begin
      starve_d = starve_q;
    end
  end

  // Output stage next-state; x0 writes are consumed with the enable held low.
  always_comb begin
    wen_d = 1'b0;
    idx_d = idx_q;
    dat_d = dat_q;
    if (lsu_win_s) begin
      wen_d = (head_idx_s != IDX_ZERO_C);
      idx_d = head_idx_s;
      dat_d = head_dat_s;
    end else if (alu_win_s) begin
      wen_d = (i_alu_idx != IDX_ZERO_C);
      idx_d = i_alu_idx;
      dat_d = i_alu_dat;
    end else begin
      wen_d = 1'b0;
      idx_d = idx_q;
      dat_d = dat_q;
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO_C;
      starve_q <= ST_ZERO_C;
      wen_q    <= 1'b0;
      idx_q    <= IDX_ZERO_C;
      dat_q    <= {XLEN{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
    end
  end

  // FIFO payload storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LSU_DEPTH; i++) begin
        mem_idx_q[i] <= IDX_ZERO_C;
        mem_dat_q[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      mem_idx_q[wr_ptr_q] <= i_lsu_idx;
      mem_dat_q[wr_ptr_q] <= i_lsu_dat;
    end else begin
      for (int i = 0; i < LSU_DEPTH; i++) begin
        mem_idx_q[i] <= mem_idx_q[i];
        mem_dat_q[i] <= mem_dat_q[i];
      end
    end
  end

  assign wbck_dest_wen = wen_q;
  assign wbck_dest_idx = idx_q;
  assign wbck_dest_dat = dat_q;
  assign o_lsu_pending = nonempty_s;

`ifdef WBCK_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall counter next-state; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_alu_valid && !o_alu_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_alu_stall_cnt = stall_cnt_q;
`endif

endmodule
